// File: rtl/dct_scale_sat.sv
// dct_scale_sat
// Output scaler for the DCT datapath. Divides the wide complex result of the
// vector-rotation stage by a power of two chosen from the FFT size, rounds
// (truncate / half-up / half-even), saturates to wDataOut bits and presents
// the result on a two-stage elastic valid/ready pipeline with per-beat and
// per-frame overflow reporting.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   sink_valid/sink_ready           input handshake
//   sink_sop/sink_eop/sink_error    frame delimiters and error bits
//   sink_real/sink_imag             signed input sample (wDataIn)
//   fftpts_in                       FFT size, latched on an accepted sop
//   round_mode                      0 trunc, 1/3 half-up, 2 half-even
//   source_valid/source_ready       output handshake
//   source_sop/source_eop           delayed frame delimiters
//   source_error                    {sink_error[1] | cfg_err, sink_error[0]}
//   source_real/source_imag         scaled, saturated sample (wDataOut)
//   fftpts_out                      FFT size of the frame being output
//   overflow                        a clamp happened on this output beat
//   frame_done                      pulse on the accepted eop output beat
//   frame_ovf_cnt                   saturated-beat count of the finished frame
module dct_scale_sat #(
    parameter int wDataIn    = 48,
    parameter int wDataOut   = 24,
    parameter int BASE_SHIFT = 16,
    parameter int LOG2_NMAX  = 11,
    parameter int LOG2_NMIN  = 6,
    parameter int wCnt       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sink_valid,
    output logic                       sink_ready,
    input  logic                       sink_sop,
    input  logic                       sink_eop,
    input  logic [1:0]                 sink_error,
    input  logic signed [wDataIn-1:0]  sink_real,
    input  logic signed [wDataIn-1:0]  sink_imag,
    input  logic [11:0]                fftpts_in,
    input  logic [1:0]                 round_mode,
    output logic                       source_valid,
    input  logic                       source_ready,
    output logic                       source_sop,
    output logic                       source_eop,
    output logic [1:0]                 source_error,
    output logic signed [wDataOut-1:0] source_real,
    output logic signed [wDataOut-1:0] source_imag,
    output logic [11:0]                fftpts_out,
    output logic                       overflow,
    output logic                       frame_done,
    output logic [wCnt-1:0]            frame_ovf_cnt
);

    localparam int SW = 8;
    localparam logic [SW-1:0]        SH_BASE = SW'(BASE_SHIFT);
    localparam logic [11:0]          FFT_RST = 12'(2 ** LOG2_NMAX);
    localparam logic [wDataIn:0]     ONE_X   = {{wDataIn{1'b0}}, 1'b1};
    localparam logic signed [wDataIn:0] MAXV =
        {{(wDataIn - wDataOut + 2){1'b0}}, {(wDataOut - 1){1'b1}}};
    localparam logic signed [wDataIn:0] MINV =
        {{(wDataIn - wDataOut + 2){1'b1}}, {(wDataOut - 1){1'b0}}};
    localparam logic [wCnt-1:0]      CNT_ONE = {{(wCnt - 1){1'b0}}, 1'b1};
    localparam logic [wCnt-1:0]      CNT_MAX = {wCnt{1'b1}};

    // Decode an FFT size into {cfg_err, shift}. Illegal sizes fall back to
    // the base shift; two FFT sizes share each shift step.
    function automatic logic [SW:0] cfg_decode(input logic [11:0] n);
        logic [3:0]    l;
        logic          pow2;
        logic          in_rng;
        logic [SW-1:0] sh;
        l = 4'd0;
        for (int i = 0; i < 12; i++) begin
            l = n[i] ? 4'(i) : l;
        end
        pow2   = (n != 12'd0) && ((n & (n - 12'd1)) == 12'd0);
        in_rng = (l >= 4'(LOG2_NMIN)) && (l <= 4'(LOG2_NMAX));
        if (pow2 && in_rng) begin
            sh = SH_BASE - ((SW'(LOG2_NMAX) - {{(SW - 4){1'b0}}, l}) >> 1);
            return {1'b0, sh};
        end else begin
            return {1'b1, SH_BASE};
        end
    endfunction

    // Shift, round and saturate one component; returns {clamped, value}.
    // Works in wDataIn+1 bits so the rounding increment can never wrap.
    function automatic logic [wDataOut:0] round_sat(
        input logic signed [wDataIn-1:0] x,
        input logic [SW-1:0]             sh,
        input logic [1:0]                mode
    );
        logic signed [wDataIn:0] xe;
        logic signed [wDataIn:0] q;
        logic signed [wDataIn:0] res;
        logic [wDataIn:0]        bit_r;
        logic                    r;
        logic                    s;
        logic                    inc;
        xe    = {x[wDataIn-1], x};
        q     = xe >>> sh;
        bit_r = ONE_X << (sh - SW'(1));
        r     = |($unsigned(xe) & bit_r);
        s     = |($unsigned(xe) & (bit_r - ONE_X));
        case (mode)
            2'd0:    inc = 1'b0;
            2'd2:    inc = r & (s | q[0]);
            default: inc = r;
        endcase
        res = q + $signed({{wDataIn{1'b0}}, inc});
        if (res > MAXV) begin
            return {1'b1, 1'b0, {(wDataOut - 1){1'b1}}};
        end else if (res < MINV) begin
            return {1'b1, 1'b1, {(wDataOut - 1){1'b0}}};
        end else begin
            return {1'b0, res[wDataOut-1:0]};
        end
    endfunction

    // Frame configuration latched on sop
    logic [SW-1:0]  shift_frame_r;
    logic           cfg_err_r;
    logic [11:0]    fftpts_frame_r;

    // Stage 1
    logic                      v1_r;
    logic signed [wDataIn-1:0] re1_r, im1_r;
    logic [SW-1:0]             sh1_r;
    logic [1:0]                mode1_r;
    logic                      sop1_r, eop1_r;
    logic [1:0]                err1_r;
    logic [11:0]               fft1_r;

    // Stage 2
    logic                       v2_r;
    logic signed [wDataOut-1:0] re2_r, im2_r;
    logic                       ovf2_r;
    logic                       sop2_r, eop2_r;
    logic [1:0]                 err2_r;
    logic [11:0]                fft2_r;
    logic [wCnt-1:0]            cnt_run_r;
    logic [wCnt-1:0]            frame_cnt_r;

    // Handshake / combinational datapath
    logic                s2_ready_s;
    logic                s1_to_s2_s;
    logic                sink_acc_s;
    logic [SW:0]         cfg_s;
    logic [SW-1:0]       sh_in_s;
    logic                cfg_err_in_s;
    logic [11:0]         fft_in_s;
    logic [wDataOut:0]   rs_re_s, rs_im_s;
    logic                ovf_s;
    logic [wCnt-1:0]     cnt_base_s, cnt_next_s;

    assign s2_ready_s = !v2_r || source_ready;
    assign s1_to_s2_s = v1_r && s2_ready_s;
    assign sink_ready = !v1_r || s2_ready_s;
    assign sink_acc_s = sink_valid && sink_ready;

    // Per-beat configuration: a sop beat already uses its own frame's shift
    always_comb begin
        cfg_s        = cfg_decode(fftpts_in);
        sh_in_s      = shift_frame_r;
        cfg_err_in_s = cfg_err_r;
        fft_in_s     = fftpts_frame_r;
        if (sink_sop) begin
            sh_in_s      = cfg_s[SW-1:0];
            cfg_err_in_s = cfg_s[SW];
            fft_in_s     = fftpts_in;
        end else begin
            sh_in_s      = shift_frame_r;
            cfg_err_in_s = cfg_err_r;
            fft_in_s     = fftpts_frame_r;
        end
    end

    // Rounding/saturation of the stage-1 beat and running overflow count
    always_comb begin
        rs_re_s    = round_sat(re1_r, sh1_r, mode1_r);
        rs_im_s    = round_sat(im1_r, sh1_r, mode1_r);
        ovf_s      = rs_re_s[wDataOut] | rs_im_s[wDataOut];
        cnt_base_s = sop1_r ? {wCnt{1'b0}} : cnt_run_r;
        if (ovf_s && (cnt_base_s != CNT_MAX)) begin
            cnt_next_s = cnt_base_s + CNT_ONE;
        end else begin
            cnt_next_s = cnt_base_s;
        end
    end

    // Frame configuration register, updated on every accepted sop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_frame_r  <= SH_BASE;
            cfg_err_r      <= 1'b0;
            fftpts_frame_r <= FFT_RST;
        end else if (sink_acc_s && sink_sop) begin
            shift_frame_r  <= cfg_s[SW-1:0];
            cfg_err_r      <= cfg_s[SW];
            fftpts_frame_r <= fftpts_in;
        end
    end

    // Stage 1: capture the accepted beat with its shift and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            re1_r   <= {wDataIn{1'b0}};
            im1_r   <= {wDataIn{1'b0}};
            sh1_r   <= SH_BASE;
            mode1_r <= 2'd0;
            sop1_r  <= 1'b0;
            eop1_r  <= 1'b0;
            err1_r  <= 2'd0;
            fft1_r  <= FFT_RST;
        end else if (sink_acc_s) begin
            v1_r    <= 1'b1;
            re1_r   <= sink_real;
            im1_r   <= sink_imag;
            sh1_r   <= sh_in_s;
            mode1_r <= round_mode;
            sop1_r  <= sink_sop;
            eop1_r  <= sink_eop;
            err1_r  <= {sink_error[1] | cfg_err_in_s, sink_error[0]};
            fft1_r  <= fft_in_s;
        end else if (s1_to_s2_s) begin
            v1_r    <= 1'b0;
        end
    end

    // Stage 2: registered rounded/saturated output and frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r        <= 1'b0;
            re2_r       <= {wDataOut{1'b0}};
            im2_r       <= {wDataOut{1'b0}};
            ovf2_r      <= 1'b0;
            sop2_r      <= 1'b0;
            eop2_r      <= 1'b0;
            err2_r      <= 2'd0;
            fft2_r      <= FFT_RST;
            cnt_run_r   <= {wCnt{1'b0}};
            frame_cnt_r <= {wCnt{1'b0}};
        end else if (s2_ready_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                re2_r     <= rs_re_s[wDataOut-1:0];
                im2_r     <= rs_im_s[wDataOut-1:0];
                ovf2_r    <= ovf_s;
                sop2_r    <= sop1_r;
                eop2_r    <= eop1_r;
                err2_r    <= err1_r;
                fft2_r    <= fft1_r;
                cnt_run_r <= cnt_next_s;
                // The eop beat carries its frame's final count while it waits in S2
                if (eop1_r) begin
                    frame_cnt_r <= cnt_next_s;
                end
            end
        end
    end

    assign source_valid  = v2_r;
    assign source_real   = re2_r;
    assign source_imag   = im2_r;
    assign overflow      = ovf2_r;
    assign source_sop    = sop2_r;
    assign source_eop    = eop2_r;
    assign source_error  = err2_r;
    assign fftpts_out    = fft2_r;
    assign frame_ovf_cnt = frame_cnt_r;
    assign frame_done    = v2_r && eop2_r && source_ready;

endmodule

// File: doc/dct_scale_sat.md
# dct_scale_sat

Parametrised output scaler for the DCT datapath. It takes the wide complex result of the vector-rotation stage and divides it by a power of two chosen from the FFT size. It then rounds with a selectable mode, saturates to the output width, and presents the result on a fully back-pressured valid/ready stream. It sits between the DCT vector-rotation multiplier and the DCT output buffer, and it adds per-beat and per-frame overflow reporting.

## Interface
- wDataIn, 48, input sample width (signed, two's complement)
- wDataOut, 24, output sample width (signed)
- BASE_SHIFT, 16, right-shift applied at the largest FFT size
- LOG2_NMAX, 11, log2 of the largest supported FFT size (2048)
- LOG2_NMIN, 6, log2 of the smallest supported FFT size (64)
- wCnt, 16, width of the per-frame saturation counter
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- sink_valid / sink_ready  in / out  1 / 1  input handshake
- sink_sop / sink_eop  in  1 each  frame delimiters
- sink_error  in  2  passed through with the data
- sink_real / sink_imag  in  wDataIn each  input sample
- fftpts_in  in  12  FFT size for the frame
- round_mode  in  2  0 = truncate, 1 = round-half-up, 2 = round-half-even, 3 = same as 1
- source_valid / source_ready  out / in  1 / 1  output handshake
- source_sop / source_eop  out  1 each  delayed frame delimiters
- source_error  out  2  bit0 = sink_error[0]; bit1 = sink_error[1] OR cfg_err of the frame
- source_real / source_imag  out  wDataOut each  scaled sample
- fftpts_out  out  12  fftpts latched for the frame being output
- overflow  out  1  high with an output beat in which real or imag saturated
- frame_done  out  1  one-cycle pulse on the accepted source_eop beat
- frame_ovf_cnt  out  wCnt  count of saturated beats in the completed frame, valid while frame_done is high, held afterwards

## Operation
- A beat is accepted when sink_valid && sink_ready.
- On an accepted sop beat, fftpts_in is latched and shift = BASE_SHIFT − ((LOG2_NMAX − log2 N) >> 1).
  - Resulting shifts for the defaults: 2048/1024 → 16, 512/256 → 15, 128/64 → 14.
- cfg_err is set for the frame when fftpts_in is not a power of two or lies outside 2^LOG2_NMIN..2^LOG2_NMAX. In that case shift = BASE_SHIFT.
- Beats before the first sop after reset use BASE_SHIFT.
- The datapath is two stages: S1 registers the samples, shift and flags; S2 performs the rounding and saturation.
- Rounding, computed in wDataIn+1 bits so it never wraps. q = x >>> shift; r = bit shift−1; s = OR of the bits below r.
  - Mode 0: result = q.
  - Mode 1: result = q + r.
  - Mode 2: result = q + (r & (s | q[0])).
- Saturation happens after rounding:
  - result > 2^(wDataOut−1)−1 → 0x7FF..F
  - result < −2^(wDataOut−1) → 0x800..0
  - Real and imag are handled independently.
- overflow is set only when a clamp actually happened. A legal output that equals full scale does not set it.
- Frame counter:
  - Cleared on every accepted sop (a sop without a preceding eop restarts it).
  - Incremented on each output beat that has overflow set, saturating at 2^wCnt−1.
  - On the accepted eop output beat, frame_ovf_cnt = the final count, including that beat.
- round_mode is sampled per beat at S1 entry.

## Timing
- Latency from input acceptance to source_valid is 2 cycles when there is no backpressure. Throughput is 1 beat per cycle.
- Elastic pipeline:
  - sink_ready = !v1 | !v2 | source_ready.
  - Each stage holds its contents while its downstream is stalled.
  - No beat is dropped or duplicated.
- While source_valid && !source_ready, all source_* outputs, overflow and fftpts_out are held stable.
- At most 2 beats are accepted after source_ready falls before sink_ready goes low.
- Reset values:
  - Outputs: source_valid, sop, eop, overflow and frame_done = 0; source_real/imag = 0; source_error = 0; frame_ovf_cnt = 0; fftpts_out = 2048.
  - Internal: shift = BASE_SHIFT, cfg_err = 0.
- Reset asserted mid-frame empties the pipeline immediately and discards the partial frame. frame_done does not fire for it.
- sop and eop on the same beat form a 1-beat frame. frame_done fires with the count of that single beat.

## Test plan
- fftpts=2048, real=0x2_8000 (2.5) → mode 0: 2, mode 1: 3, mode 2: 2. real=0x3_8000 → mode 2: 4. imag=−0x1_8000 → mode 1: −1, mode 2: −2.
- fftpts=512, real=0x8000 → 1 (shift 15). fftpts=64, real=0x4000 → 1 (shift 14). fftpts=100 → shift 16, source_error[1]=1 for the whole frame.
- real=2^40 → 0x7FFFFF with overflow=1. real=−2^40 → 0x800000 with overflow=1. real=0x7FFFFF_0000 → 0x7FFFFF with overflow=0. real=0x7FFFFF_8000 in mode 1 → 0x7FFFFF with overflow=1 (the rounding carry is clamped).
- Stream 10 beats with values 1..10 (×65536). Hold source_ready low for 5 cycles after beat 3 → sink_ready drops within 2 cycles, output stays 1..10 in order, and source_* is stable during the stall.
- 64-beat frame with saturating beats at indices 5, 6 and 63 → frame_done pulses on the eop beat with frame_ovf_cnt=3. A following frame with none → 0.
- Assert rst_n low at beat 20 of a frame → source_valid=0 asynchronously, no frame_done. The next frame starts cleanly with its counter at 0.
